// File: rtl/arbiter_4_v.sv
// Four-requester arbiter with registered one-hot grant, hold timeout and post-timeout exclusion mask.
// Define ARBITER_4_V_ROUND_ROBIN_EN for rotating priority; default build is fixed priority (line 0 highest).
module arbiter_4_v #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_req,
   output logic [3:0] o_gnt,
   output logic [1:0] o_gnt_code,
   output logic       o_gnt_valid,
   output logic       o_timeout
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_e;

   localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   state_e     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       timeout_q, timeout_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] mask_q, mask_d;

   logic [3:0] masked_req;
   logic       win_found;
   logic [1:0] win_code;
   logic [7:0] hold_inc;

   assign masked_req = i_req & ~mask_q;
   assign hold_inc   = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;

`ifdef ARBITER_4_V_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] idx;

   // Descending scan so the smallest distance from the pointer is the last (winning) hit.
   always_comb begin
      win_found = 1'b0;
      win_code  = 2'd0;
      idx       = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (masked_req[idx]) begin
            win_found = 1'b1;
            win_code  = idx;
         end
      end
   end
`else
   always_comb begin
      win_found = 1'b0;
      win_code  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (masked_req[i]) begin
            win_found = 1'b1;
            win_code  = 2'(i);
         end
      end
   end
`endif

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_d   = state_q;
      gnt_d     = gnt_q;
      code_d    = code_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      mask_d    = mask_q;
`ifdef ARBITER_4_V_ROUND_ROBIN_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            mask_d = 4'b0000;
            if (win_found) begin
               gnt_d   = 4'b0001 << win_code;
               code_d  = win_code;
               valid_d = 1'b1;
               hold_d  = 8'd0;
               state_d = S_GRANT;
`ifdef ARBITER_4_V_ROUND_ROBIN_EN
               ptr_d   = win_code + 2'd1;
`endif
            end
         end
         S_GRANT: begin
            hold_d = hold_inc;
            if (!i_req[code_q]) begin
               gnt_d   = 4'b0000;
               code_d  = 2'd0;
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
               // Forced release: exclude the evicted owner from the next arbitration only.
               gnt_d     = 4'b0000;
               code_d    = 2'd0;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
               mask_d    = gnt_q;
               state_d   = S_IDLE;
            end
         end
         default: begin
            gnt_d   = 4'b0000;
            code_d  = 2'd0;
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= 4'b0000;
         code_q    <= 2'd0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= 8'd0;
         mask_q    <= 4'b0000;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         mask_q    <= mask_d;
      end
   end

`ifdef ARBITER_4_V_ROUND_ROBIN_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ptr_q <= 2'd0;
      else          ptr_q <= ptr_d;
   end
`endif

   assign o_gnt       = gnt_q;
   assign o_gnt_code  = code_q;
   assign o_gnt_valid = valid_q;
   assign o_timeout   = timeout_q;

endmodule
